// File: rtl/mssb_req_scheduler.sv
// Most-significant-set-bit request scheduler with held grants and optional tenure limit.
// Define MSSB_REQ_SCHEDULER_ROUNDROBIN_EN to add the descending round-robin preference mask.
module mssb_req_scheduler #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MAX_HOLD = 0
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_cg,
  input  logic [WIDTH-1:0]         i_req,
  output logic [WIDTH-1:0]         o_gnt,
  output logic [$clog2(WIDTH)-1:0] o_gntIdx,
  output logic                     o_gntValid
);

  localparam int unsigned IW = $clog2(WIDTH);
  localparam int unsigned TW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] gnt_q, gnt_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             valid_q, valid_d;
  logic [IW-1:0]    win_idx;
  logic             load_c, clr_c, inc_c, expire_c;

  function automatic logic [IW-1:0] mssb(input logic [WIDTH-1:0] v);
    logic [IW-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (v[i]) r = IW'(i);
    end
    return r;
  endfunction

`ifdef MSSB_REQ_SCHEDULER_ROUNDROBIN_EN
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] masked_req;

  // Prefer indices below the last winner; wrap to the full request vector if none ask.
  always_comb begin
    masked_req = i_req & mask_q;
    win_idx    = (|masked_req) ? mssb(masked_req) : mssb(i_req);
    mask_d     = mask_q;
    if (load_c) begin
      for (int unsigned i = 0; i < WIDTH; i++) mask_d[i] = (IW'(i) < win_idx);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)     mask_q <= '1;
    else if (i_cg) mask_q <= mask_d;
  end
`else
  always_comb win_idx = mssb(i_req);
`endif

  // Tenure counter exists only when a hold limit is configured.
  generate
    if (MAX_HOLD != 0) begin : g_tenure
      logic [TW-1:0] ten_q;

      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          ten_q <= '0;
        end else if (i_cg) begin
          if (load_c)                                ten_q <= TW'(1);
          else if (clr_c)                            ten_q <= '0;
          else if (inc_c && ten_q != TW'(MAX_HOLD))  ten_q <= ten_q + TW'(1);
        end
      end

      assign expire_c = (ten_q == TW'(MAX_HOLD));
    end else begin : g_no_tenure
      logic unused_ten;
      assign unused_ten = inc_c ^ clr_c;
      assign expire_c   = 1'b0;
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    load_c  = 1'b0;
    clr_c   = 1'b0;
    inc_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (|i_req) begin
          state_d = GRANT;
          gnt_d   = WIDTH'(1) << win_idx;
          idx_d   = win_idx;
          valid_d = 1'b1;
          load_c  = 1'b1;
        end
      end
      GRANT: begin
        if (!i_req[idx_q] || expire_c) begin
          state_d = IDLE;
          gnt_d   = '0;
          idx_d   = '0;
          valid_d = 1'b0;
          clr_c   = 1'b1;
        end else begin
          inc_c = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else if (i_cg) begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

  assign o_gnt      = gnt_q;
  assign o_gntIdx   = idx_q;
  assign o_gntValid = valid_q;

endmodule

// File: tb/tb_mssb_req_scheduler.sv
// Randomised and directed bench for mssb_req_scheduler (WIDTH=4, MAX_HOLD=3) against a behavioural model.
module tb_mssb_req_scheduler;

  localparam int W  = 4;
  localparam int MH = 3;

  logic         i_clk = 1'b0;
  logic         i_rst;
  logic         i_cg;
  logic [W-1:0] i_req;
  logic [W-1:0] o_gnt;
  logic [1:0]   o_gntIdx;
  logic         o_gntValid;

  int total = 0;
  int bad   = 0;

  // Model: current owner (-1 = none), cycles held so far, preferred-index mask.
  int m_owner = -1;
  int m_ten   = 0;
  int m_mask  = (1 << W) - 1;

  mssb_req_scheduler #(.WIDTH(W), .MAX_HOLD(MH)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_cg(i_cg), .i_req(i_req),
    .o_gnt(o_gnt), .o_gntIdx(o_gntIdx), .o_gntValid(o_gntValid)
  );

  always #5 i_clk = ~i_clk;

  function automatic int hibit(input int x);
    return $clog2(x + 1) - 1;
  endfunction

  task automatic model_step();
    int r, k;
    r = int'(i_req);
    if (i_rst) begin
      m_owner = -1; m_ten = 0; m_mask = (1 << W) - 1;
    end else if (i_cg) begin
      if (m_owner < 0) begin
        if (r != 0) begin
          k = ((r & m_mask) != 0) ? hibit(r & m_mask) : hibit(r);
          m_owner = k;
          m_ten   = 1;
`ifdef MSSB_REQ_SCHEDULER_ROUNDROBIN_EN
          m_mask  = (1 << k) - 1;
`endif
        end
      end else if (((r >> m_owner) & 1) == 0 || m_ten == MH) begin
        m_owner = -1; m_ten = 0;
      end else if (m_ten < MH) begin
        m_ten++;
      end
    end
  endtask

  task automatic compare();
    logic [W-1:0] eg;
    logic [1:0]   ei;
    eg = (m_owner < 0) ? '0 : W'(1) << m_owner;
    ei = (m_owner < 0) ? 2'd0 : 2'(m_owner);
    total++;
    if (o_gnt !== eg || o_gntIdx !== ei || o_gntValid !== (m_owner >= 0)) begin
      bad++;
      $display("FAIL model t=%0t gnt=%b idx=%0d vld=%b expected gnt=%b idx=%0d vld=%b",
               $time, o_gnt, o_gntIdx, o_gntValid, eg, ei, (m_owner >= 0));
    end
  endtask

  task automatic lit(input string name, input logic [W-1:0] g, input logic [1:0] ix);
    total++;
    if (o_gnt !== g || o_gntIdx !== ix || o_gntValid !== (|g)) begin
      bad++;
      $display("FAIL %s gnt=%b idx=%0d vld=%b expected gnt=%b idx=%0d vld=%b",
               name, o_gnt, o_gntIdx, o_gntValid, g, ix, |g);
    end
  endtask

  task automatic cyc(input logic r, input logic cg, input logic [W-1:0] q);
    i_rst = r; i_cg = cg; i_req = q;
    @(posedge i_clk);
    model_step();
    #1;
    compare();
  endtask

  initial begin
    logic [W-1:0] seq_g [16];
    logic [W-1:0] rq;

    // Reset, then first grant to the highest active index.
    cyc(1, 1, 4'b0101); lit("reset0", 4'b0000, 2'd0);
    cyc(1, 1, 4'b0101); lit("reset1", 4'b0000, 2'd0);
    cyc(0, 1, 4'b0101); lit("first_grant", 4'b0100, 2'd2);
    // Release by owner, one idle cycle, then the remaining requester.
    cyc(0, 1, 4'b0001); lit("release_idle", 4'b0000, 2'd0);
    cyc(0, 1, 4'b0001); lit("next_owner", 4'b0001, 2'd0);
    cyc(0, 1, 4'b0000); lit("drop_last", 4'b0000, 2'd0);

    // All requesting: tenure expiry sequence from a fresh mask.
`ifdef MSSB_REQ_SCHEDULER_ROUNDROBIN_EN
    seq_g = '{4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0000,
              4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0000};
`else
    seq_g = '{4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b1000, 4'b1000, 4'b1000, 4'b0000,
              4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b1000, 4'b1000, 4'b1000, 4'b0000};
`endif
    cyc(1, 1, 4'b0000);
    for (int i = 0; i < 16; i++) begin
      cyc(0, 1, 4'b1111);
      lit("tenure_seq", seq_g[i], (seq_g[i] == 0) ? 2'd0 : 2'(hibit(int'(seq_g[i]))));
    end
    cyc(0, 1, 4'b1111); lit("tenure_wrap", 4'b1000, 2'd3);

    // Grant 1, release, then 4'b1010 must go to 3 (mask wraps in the RR build).
    cyc(1, 1, 4'b0000);
    cyc(0, 1, 4'b0010); lit("wrap_g1", 4'b0010, 2'd1);
    cyc(0, 1, 4'b1000); lit("wrap_rel", 4'b0000, 2'd0);
    cyc(0, 1, 4'b1010); lit("wrap_g3", 4'b1000, 2'd3);

    // Reset mid-grant at tenure 2 restores the mask.
    cyc(1, 1, 4'b0000);
    cyc(0, 1, 4'b0100); lit("mid_g2", 4'b0100, 2'd2);
    cyc(0, 1, 4'b1111); lit("mid_ten2", 4'b0100, 2'd2);
    cyc(1, 1, 4'b1111); lit("mid_rst", 4'b0000, 2'd0);
    cyc(0, 1, 4'b1111); lit("mid_after", 4'b1000, 2'd3);

    // Clock gate low freezes a tenure-1 grant; tenure resumes afterwards.
    cyc(1, 1, 4'b0000);
    cyc(0, 1, 4'b0100); lit("cg_grant", 4'b0100, 2'd2);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, (i % 2 == 0) ? 4'b0000 : 4'b1011);
      lit("cg_hold", 4'b0100, 2'd2);
    end
    cyc(0, 1, 4'b0100); lit("cg_ten2", 4'b0100, 2'd2);
    cyc(0, 1, 4'b0100); lit("cg_ten3", 4'b0100, 2'd2);
    cyc(0, 1, 4'b0100); lit("cg_expire", 4'b0000, 2'd0);

    // Randomised traffic against the model.
    rq = 4'b0000;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) rq = W'($urandom_range(0, 15));
      cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) != 0), rq);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
